// File: rtl/truth_table_checker_pkg.sv
// Shared widths and FSM state type for the exhaustive 4-in/3-out truth table checker.
package truth_table_checker_pkg;
    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 3;
    localparam int unsigned N_VEC = 16;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;
endpackage

// File: rtl/tt_expected_lut.sv
// Expected {f,g,h} for a 4-bit input vector, looked up from three 16-bit truth table masks.
module tt_expected_lut
    import truth_table_checker_pkg::*;
#(
    parameter logic [N_VEC-1:0] EXP_F = 16'h0000,
    parameter logic [N_VEC-1:0] EXP_G = 16'h0000,
    parameter logic [N_VEC-1:0] EXP_H = 16'h0000
) (
    input  logic [N_IN-1:0]  idx,
    output logic [N_OUT-1:0] exp_bits
);
    always_comb begin
        exp_bits = {EXP_F[idx], EXP_G[idx], EXP_H[idx]};
    end
endmodule

// File: rtl/truth_table_checker.sv
// Sweeps vectors 0..15, holds each SETTLE cycles, then compares the sampled response with the
// expected truth tables and reports the mismatch count and the first failing vector.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int unsigned      SETTLE = 1,
    parameter logic [N_VEC-1:0] EXP_F  = 16'h0000,
    parameter logic [N_VEC-1:0] EXP_G  = 16'h0000,
    parameter logic [N_VEC-1:0] EXP_H  = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [N_IN-1:0]    vec,
    input  logic [N_OUT-1:0]   resp,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [N_IN-1:0]    first_err_idx,
    output logic [N_OUT-1:0]   first_err_bits
);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  LAST_VEC    = N_IN'(N_VEC - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [N_IN-1:0]   vec_n;
    logic              busy_n, done_n, pass_n;
    logic [CNT_W-1:0]  err_count_n;
    logic [N_IN-1:0]   first_err_idx_n;
    logic [N_OUT-1:0]  first_err_bits_n;
    logic              has_err, has_err_n;

    logic [N_OUT-1:0]  exp_bits;
    logic [N_OUT-1:0]  diff;
    logic              mismatch;
    logic [CNT_W-1:0]  err_inc;

    tt_expected_lut #(
        .EXP_F(EXP_F),
        .EXP_G(EXP_G),
        .EXP_H(EXP_H)
    ) u_lut (
        .idx      (vec),
        .exp_bits (exp_bits)
    );

    always_comb begin
        diff     = resp ^ exp_bits;
        mismatch = |diff;
        err_inc  = err_count + CNT_W'(mismatch);
    end

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        vec_n            = vec;
        busy_n           = busy;
        done_n           = done;
        pass_n           = pass;
        err_count_n      = err_count;
        first_err_idx_n  = first_err_idx;
        first_err_bits_n = first_err_bits;
        has_err_n        = has_err;

        case (state)
            IDLE, DONE: begin
                vec_n = '0;
                if (start) begin
                    err_count_n      = '0;
                    first_err_idx_n  = '0;
                    first_err_bits_n = '0;
                    has_err_n        = 1'b0;
                    cnt_n            = '0;
                    busy_n           = 1'b1;
                    done_n           = 1'b0;
                    pass_n           = 1'b0;
                    state_n          = DRIVE;
                end
            end
            DRIVE: begin
                cnt_n = cnt + 1'b1;
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                err_count_n = err_inc;
                if (mismatch && !has_err) begin
                    first_err_idx_n  = vec;
                    first_err_bits_n = diff;
                    has_err_n        = 1'b1;
                end
                // pass uses the count including this last comparison
                if (vec == LAST_VEC) begin
                    vec_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_inc == '0);
                    state_n = DONE;
                end else begin
                    vec_n   = vec + 1'b1;
                    cnt_n   = '0;
                    state_n = DRIVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            vec            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_bits <= '0;
            has_err        <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            vec            <= vec_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_count_n;
            first_err_idx  <= first_err_idx_n;
            first_err_bits <= first_err_bits_n;
            has_err        <= has_err_n;
        end
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// Bench: two checkers (SETTLE=1 loopback, SETTLE=3 with glitching response) against a timeline model.
module tb_truth_table_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start1, start3;
    logic [3:0] vec1, vec3;
    logic [2:0] resp1, resp3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [4:0] err1, err3;
    logic [3:0] idx1, idx3;
    logic [2:0] bits1, bits3;

    logic [2:0] fault1 [16];
    logic [2:0] fault3 [16];
    logic [2:0] mf1 [16];
    logic [2:0] mf3 [16];
    int k1 = -1;
    int k3 = -1;
    bit model_ok = 1'b0;

    int checks = 0;
    int errors = 0;

    truth_table_checker #(
        .SETTLE(1), .EXP_F(16'hF0F0), .EXP_G(16'hCCCC), .EXP_H(16'hAAAA)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .vec(vec1), .resp(resp1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_idx(idx1), .first_err_bits(bits1)
    );

    truth_table_checker #(
        .SETTLE(3), .EXP_F(16'hF0F0), .EXP_G(16'hCCCC), .EXP_H(16'hAAAA)
    ) dut3 (
        .clk(clk), .reset(reset), .start(start3), .vec(vec3), .resp(resp3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_idx(idx3), .first_err_bits(bits3)
    );

    // Exercise block: f=B, g=C, h=D, with an optional per-vector fault mask.
    always_comb resp1 = vec1[2:0] ^ fault1[vec1];

    // Correct only in the cycle feeding a sampling edge, noise elsewhere.
    always @(negedge clk) begin
        if (k3 >= 0 && k3 < 64 && ((k3 + 1) % 4) == 0)
            resp3 <= vec3[2:0] ^ fault3[vec3];
        else
            resp3 <= 3'($urandom);
    end

    typedef struct packed {
        logic [3:0] vec;
        logic       busy;
        logic       done;
        logic       pass;
        logic [4:0] err;
        logic [3:0] idx;
        logic [2:0] bits;
    } exp_t;

    // k = edges since start was accepted (-1 = idle since reset).
    function automatic exp_t model(input int k, input int s, input logic [2:0] f [16]);
        exp_t e;
        int len, ns;
        e = '0;
        if (k < 0) return e;
        len = 16 * (s + 1);
        e.busy = (k < len);
        e.done = (k >= len);
        if (e.busy) e.vec = 4'(k / (s + 1));
        ns = k / (s + 1);
        if (ns > 16) ns = 16;
        for (int n = 0; n < ns; n++) begin
            if (f[n] != 3'b000) begin
                if (e.err == 5'd0) begin
                    e.idx  = 4'(n);
                    e.bits = f[n];
                end
                e.err = e.err + 5'd1;
            end
        end
        e.pass = e.done && (e.err == 5'd0);
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            k1 <= -1;
            k3 <= -1;
            model_ok <= 1'b1;
        end else begin
            if ((k1 < 0 || k1 >= 32) && start1) begin
                k1 <= 0;
                mf1 <= fault1;
            end else if (k1 >= 0 && k1 < 32) begin
                k1 <= k1 + 1;
            end
            if ((k3 < 0 || k3 >= 64) && start3) begin
                k3 <= 0;
                mf3 <= fault3;
            end else if (k3 >= 0 && k3 < 64) begin
                k3 <= k3 + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [3:0] v, input logic b,
                       input logic d, input logic p, input logic [4:0] er,
                       input logic [3:0] ix, input logic [2:0] bt);
        chk({tag, "_vec"}, v, e.vec);
        chk({tag, "_busy"}, b, e.busy);
        chk({tag, "_done"}, d, e.done);
        chk({tag, "_pass"}, p, e.pass);
        chk({tag, "_err_count"}, er, e.err);
        chk({tag, "_first_err_idx"}, ix, e.idx);
        chk({tag, "_first_err_bits"}, bt, e.bits);
        chk({tag, "_busy_done_excl"}, b & d, 0);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            cmp("dut1", model(k1, 1, mf1), vec1, busy1, done1, pass1, err1, idx1, bits1);
            cmp("dut3", model(k3, 3, mf3), vec3, busy3, done3, pass3, err3, idx3, bits3);
        end
    end

    task automatic sweep(input bit go1, input bit go3, output int cyc1, output int cyc3);
        int n;
        n = 0;
        cyc1 = -1;
        cyc3 = -1;
        start1 = go1;
        start3 = go3;
        while (n < 200 && !((!go1 || cyc1 >= 0) && (!go3 || cyc3 >= 0))) begin
            @(negedge clk);
            n++;
            start1 = 1'b0;
            start3 = 1'b0;
            if (go1 && cyc1 < 0 && done1 === 1'b1) cyc1 = n - 1;
            if (go3 && cyc3 < 0 && done3 === 1'b1) cyc3 = n - 1;
        end
        chk("sweep_within_bound", (n < 200), 1);
    endtask

    task automatic clear_faults();
        for (int v = 0; v < 16; v++) begin
            fault1[v] = 3'b000;
            fault3[v] = 3'b000;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int c1, c3, n, b;
        reset = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy1, 0);
        chk("reset_err_count", err1, 0);

        // Clean loopback sweep
        sweep(1'b1, 1'b0, c1, c3);
        chk("clean_cycles", c1, 32);
        chk("clean_pass", pass1, 1);
        chk("clean_err_count", err1, 0);

        // g wrong at vector 9 only
        fault1[9] = 3'b010;
        sweep(1'b1, 1'b0, c1, c3);
        chk("g9_err_count", err1, 1);
        chk("g9_first_idx", idx1, 9);
        chk("g9_first_bits", bits1, 3'b010);
        chk("g9_pass", pass1, 0);

        // All outputs inverted
        for (int v = 0; v < 16; v++) fault1[v] = 3'b111;
        sweep(1'b1, 1'b0, c1, c3);
        chk("inv_err_count", err1, 16);
        chk("inv_first_idx", idx1, 0);
        chk("inv_first_bits", bits1, 3'b111);

        // Reset at cycle 10 of a sweep
        clear_faults();
        fault1[2] = 3'b100;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_err_count", err1, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", busy1, 0);
        chk("midreset_vec", vec1, 0);
        chk("midreset_err_count", err1, 0);
        chk("midreset_first_bits", bits1, 0);
        fault1[2] = 3'b000;
        sweep(1'b1, 1'b0, c1, c3);
        chk("after_reset_cycles", c1, 32);
        chk("after_reset_pass", pass1, 1);

        // start held high across a whole sweep and into DONE
        fault1[3] = 3'b001;
        start1 = 1'b1;
        n = 0;
        b = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy1 === 1'b1) b++;
        end while (done1 !== 1'b1 && n < 100);
        chk("held_busy_cycles", b, 32);
        chk("held_err_count", err1, 1);
        @(negedge clk);
        chk("held_restart_done", done1, 0);
        chk("held_restart_busy", busy1, 1);
        chk("held_restart_err_count", err1, 0);
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_second_done", done1, 1);
        clear_faults();

        // SETTLE=3 with noise on resp between sampling edges
        sweep(1'b0, 1'b1, c1, c3);
        chk("settle3_cycles", c3, 64);
        chk("settle3_pass", pass3, 1);

        // Random fault patterns on both checkers, one sweep aborted by reset
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < 16; v++) begin
                fault1[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                fault3[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            end
            if (r == 3) begin
                start1 = 1'b1;
                start3 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                start3 = 1'b0;
                repeat ($urandom_range(5, 40)) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                sweep(1'b1, 1'b1, c1, c3);
                chk("rand_cycles1", c1, 32);
                chk("rand_cycles3", c3, 64);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
